// File: rtl/ysyx_23060136_ifu_pc_gen.sv
// ysyx_23060136 IFU: program-counter generator and IF/ID pipeline register.
// Keeps one fetch in flight at a time; a redirect can discard that fetch.
module ysyx_23060136_ifu_pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_req,
    output logic [31:0] fetch_pc,
    input  logic        fetch_done,
    input  logic [31:0] fetch_inst,
    input  logic        fetch_err,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_err
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_DRAIN
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_err_q, id_err_d;

    logic        slot_free;
    logic        capture;
    logic [31:0] redirect_tgt;

    // Low two bits of the target are forced to zero (word aligned).
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign slot_free    = !id_valid_q || id_ready;

    // A new request only when idle, the IF/ID slot drains and no redirect.
    assign fetch_req = (state_q == S_REQ) && slot_free && !redirect_valid;

    // A response is kept only for a live fetch with no redirect this cycle.
    assign capture = (state_q == S_WAIT) && fetch_done && !redirect_valid;

    assign fetch_pc = pc_q;
    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign id_err   = id_err_q;

    // Next fetch state and PC.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end else if (slot_free) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (capture) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end else if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = fetch_done ? S_REQ : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_tgt;
                end
                if (fetch_done) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    // IF/ID register: load beats handshake clear, redirect flush beats both.
    always_comb begin
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_err_d   = id_err_q;
        if (id_valid_q && id_ready) begin
            id_valid_d = 1'b0;
        end
        if (capture) begin
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            id_inst_d  = fetch_inst;
            id_err_d   = fetch_err;
        end
        if (redirect_valid) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP;
            id_err_d   = 1'b0;
        end
    end

    // State, PC and IF/ID flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            id_valid_q <= 1'b0;
            id_pc_q    <= 32'h0;
            id_inst_q  <= NOP;
            id_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            id_valid_q <= id_valid_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_err_q   <= id_err_d;
        end
    end

endmodule

// File: tb/tb_ysyx_23060136_ifu_pc_gen.sv
// Bench for ysyx_23060136_ifu_pc_gen: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_ysyx_23060136_ifu_pc_gen;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        fetch_done;
    logic [31:0] fetch_inst;
    logic        fetch_err;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_err;

    ysyx_23060136_ifu_pc_gen dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .fetch_req     (fetch_req),
        .fetch_pc      (fetch_pc),
        .fetch_done    (fetch_done),
        .fetch_inst    (fetch_inst),
        .fetch_err     (fetch_err),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .id_err        (id_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int illegal_done = 0;

    // Model: one outstanding fetch with a discard tag, plus the decode slot.
    bit          model_ok = 0;
    logic [31:0] m_pc;
    bit          m_busy;
    bit          m_drop;
    int          m_age;
    int          m_lat;
    bit          m_valid;
    logic [31:0] m_id_pc;
    logic [31:0] m_inst;
    bit          m_err;
    bit          m_req;

    bit rand_mode = 0;
    int cur_lat   = 2;
    bit err_force = 0;
    int done_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic bit exp_req();
        return !m_busy && (!m_valid || id_ready === 1'b1) &&
               redirect_valid !== 1'b1;
    endfunction

    // Reference model advances on every active edge.
    always @(posedge clk) begin
        if (rst) begin
            m_pc     = RESET_PC;
            m_busy   = 0;
            m_drop   = 0;
            m_age    = 0;
            m_valid  = 0;
            m_id_pc  = 32'h0;
            m_inst   = NOP;
            m_err    = 0;
            model_ok = 1;
        end else if (model_ok) begin
            m_req = exp_req();
            if (m_valid && id_ready) m_valid = 0;
            if (fetch_done && !m_busy) begin
                illegal_done++;
                $display("note: fetch_done with no fetch outstanding at %0t",
                         $time);
            end
            if (m_busy) begin
                if (fetch_done) begin
                    if (!m_drop && !redirect_valid) begin
                        m_valid = 1;
                        m_id_pc = m_pc;
                        m_inst  = fetch_inst;
                        m_err   = fetch_err;
                        m_pc    = m_pc + 32'd4;
                    end
                    m_busy = 0;
                    m_drop = 0;
                end else begin
                    m_age++;
                end
            end
            if (redirect_valid) begin
                m_pc    = redirect_pc & 32'hFFFF_FFFC;
                m_valid = 0;
                m_inst  = NOP;
                m_err   = 0;
                if (m_busy) m_drop = 1;
            end
            if (m_req) begin
                m_busy = 1;
                m_age  = 1;
                m_lat  = rand_mode ? int'($urandom_range(1, 4)) : cur_lat;
            end
        end
    end

    // Compare process: every out-of-reset cycle, away from the edge.
    always @(negedge clk) begin
        if (model_ok && !rst) begin
            chk("fetch_req", {31'b0, fetch_req}, {31'b0, exp_req()});
            chk("fetch_pc", fetch_pc, m_pc);
            chk("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
            chk("id_pc", id_pc, m_id_pc);
            chk("id_inst", id_inst, m_inst);
            chk("id_err", {31'b0, id_err}, {31'b0, m_err});
        end
    end

    task automatic tick(input logic rdy, input logic rv,
                        input logic [31:0] rpc);
        @(posedge clk);
        #1;
        id_ready       = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        fetch_done     = m_busy && (m_age >= m_lat);
        if (fetch_done) begin
            fetch_inst = rand_mode ? $urandom : 32'(32'hC0DE_0000 + done_cnt);
            fetch_err  = rand_mode ? ($urandom_range(0, 7) == 0) : err_force;
            done_cnt++;
        end else begin
            fetch_inst = $urandom;
            fetch_err  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic wait_valid(input int budget, input logic rdy);
        int n = 0;
        do begin
            tick(rdy, 1'b0, 32'h0);
            #1;
            n++;
        end while (id_valid !== 1'b1 && n < budget);
        if (id_valid !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_valid: no capture within %0d cycles", budget);
        end
    endtask

    task automatic wait_req(input int budget);
        int n = 0;
        do begin
            tick(1'b1, 1'b0, 32'h0);
            #1;
            n++;
        end while (fetch_req !== 1'b1 && n < budget);
        if (fetch_req !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_req: no request within %0d cycles", budget);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        id_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        fetch_done     = 1'b0;
        fetch_inst     = 32'h0;
        fetch_err      = 1'b0;
        m_lat          = 2;
        repeat (3) @(posedge clk);

        // Reset state and first request.
        tick(1'b1, 1'b0, 32'h0);
        rst = 1'b0;
        #1;
        chk("rst_fetch_req", {31'b0, fetch_req}, 32'h1);
        chk("rst_fetch_pc", fetch_pc, 32'h8000_0000);
        chk("rst_id_valid", {31'b0, id_valid}, 32'h0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_inst", id_inst, 32'h0000_0013);
        chk("rst_id_err", {31'b0, id_err}, 32'h0);

        // Sequential fetches, latency 2, no stall.
        wait_valid(10, 1'b1);
        chk("seq0_pc", id_pc, 32'h8000_0000);
        chk("seq0_inst", id_inst, 32'hC0DE_0000);
        chk("seq0_fpc", fetch_pc, 32'h8000_0004);
        wait_valid(10, 1'b1);
        chk("seq1_pc", id_pc, 32'h8000_0004);
        chk("seq1_inst", id_inst, 32'hC0DE_0001);
        wait_valid(10, 1'b1);
        chk("seq2_pc", id_pc, 32'h8000_0008);
        chk("seq2_inst", id_inst, 32'hC0DE_0002);

        // Decode stall for 5 cycles.
        wait_valid(10, 1'b0);
        chk("stall_pc", id_pc, 32'h8000_000C);
        chk("stall_req0", {31'b0, fetch_req}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            #1;
            chk("stall_inst", id_inst, 32'hC0DE_0003);
            chk("stall_req", {31'b0, fetch_req}, 32'h0);
        end
        tick(1'b1, 1'b0, 32'h0);
        #1;
        chk("unstall_req", {31'b0, fetch_req}, 32'h1);
        chk("unstall_fpc", fetch_pc, 32'h8000_0010);

        // Redirect while waiting; in-flight data dropped.
        tick(1'b1, 1'b1, 32'h8000_1002);
        tick(1'b1, 1'b0, 32'h0);
        #1;
        chk("rdw_fpc", fetch_pc, 32'h8000_1000);
        chk("rdw_valid", {31'b0, id_valid}, 32'h0);
        chk("rdw_req_drain", {31'b0, fetch_req}, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        #1;
        chk("rdw_req", {31'b0, fetch_req}, 32'h1);
        chk("rdw_req_pc", fetch_pc, 32'h8000_1000);
        chk("rdw_valid2", {31'b0, id_valid}, 32'h0);

        // Redirect together with fetch_done.
        tick(1'b1, 1'b0, 32'h0);
        tick(1'b1, 1'b1, 32'h8000_4000);
        cur_lat = 4;
        tick(1'b1, 1'b0, 32'h0);
        #1;
        chk("rdd_req", {31'b0, fetch_req}, 32'h1);
        chk("rdd_fpc", fetch_pc, 32'h8000_4000);
        chk("rdd_valid", {31'b0, id_valid}, 32'h0);

        // Two redirects during drain; latest wins.
        tick(1'b1, 1'b1, 32'h8000_2000);
        tick(1'b1, 1'b1, 32'h8000_3000);
        tick(1'b1, 1'b0, 32'h0);
        #1;
        chk("drn_fpc", fetch_pc, 32'h8000_3000);
        chk("drn_req", {31'b0, fetch_req}, 32'h0);
        cur_lat = 2;
        wait_req(10);
        chk("drn_req_pc", fetch_pc, 32'h8000_3000);
        chk("drn_valid", {31'b0, id_valid}, 32'h0);
        err_force = 1;
        wait_valid(10, 1'b1);
        err_force = 0;
        chk("err_pc", id_pc, 32'h8000_3000);
        chk("err_tag", {31'b0, id_err}, 32'h1);

        // PC wrap at the top of the address space.
        tick(1'b1, 1'b1, 32'hFFFF_FFFC);
        wait_req(10);
        chk("wrap_req_pc", fetch_pc, 32'hFFFF_FFFC);
        wait_valid(10, 1'b1);
        chk("wrap_id_pc", id_pc, 32'hFFFF_FFFC);
        chk("wrap_fpc", fetch_pc, 32'h0000_0000);

        // Reset while a fetch is outstanding; a stale response is ignored.
        tick(1'b1, 1'b0, 32'h0);
        rst = 1'b1;
        tick(1'b1, 1'b0, 32'h0);
        rst = 1'b0;
        fetch_done = 1'b1;
        fetch_inst = 32'hDEAD_BEEF;
        #1;
        chk("rstw_fpc", fetch_pc, 32'h8000_0000);
        chk("rstw_req", {31'b0, fetch_req}, 32'h1);
        chk("rstw_valid", {31'b0, id_valid}, 32'h0);
        tick(1'b1, 1'b0, 32'h0);
        #1;
        chk("rstw_stale", {31'b0, id_valid}, 32'h0);
        wait_valid(10, 1'b1);
        chk("rstw_id_pc", id_pc, 32'h8000_0000);

        // Randomized traffic against the model.
        rand_mode = 1;
        for (int i = 0; i < 4000; i++) begin
            logic        r;
            logic        v;
            logic [31:0] p;
            r = ($urandom_range(0, 9) < 7);
            v = ($urandom_range(0, 19) == 0);
            p = $urandom;
            if ($urandom_range(0, 3) == 0) p = 32'hFFFF_FFF0 | (p & 32'hF);
            tick(r, v, p);
            rst = ($urandom_range(0, 299) == 0);
        end
        tick(1'b1, 1'b0, 32'h0);
        rst = 1'b0;
        repeat (10) tick(1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
